// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch (IF) stage of the 5-stage MIPS pipeline. It owns the
// program counter, presents it as a word address to the synchronous
// instruction ROM, waits MEM_LATENCY cycles for the read data, and latches
// the returned instruction. The latched {pc, inst} pair forms the IF->ID
// bus that decode consumes.
//
// The PC is redirected in one of two ways:
//   - by decode, through jbr_bus (jump/branch, applied on a normal advance);
//   - by writeback, through exc_bus (exception entry / ERET return), which
//     is applied immediately and throws away any fetch in flight.
//
// Ports
//   clk_i          clock, all state changes on the rising edge
//   reset_i        synchronous, active-high reset
//   IF_valid_i     IF holds a valid instruction slot (pipeline control)
//   next_fetch_i   pipeline advances IF->ID this cycle
//   jbr_bus_i      {jbr_taken, jbr_target[31:0]} from decode
//   exc_bus_i      {exc_valid, exc_pc[31:0]} from writeback
//   inst_addr_o    ROM address, always equal to the current pc
//   inst_rdata_i   ROM read data
//   IF_over_o      instruction for the current pc is latched and valid
//   IF_ID_bus_o    {pc, latched instruction}
//   IF_pc_o        current pc (display)
//   IF_inst_o      latched instruction (display)
// ---------------------------------------------------------------------------
module fetch_stage #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int unsigned MEM_LATENCY = 1
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        IF_valid_i,
   input  logic        next_fetch_i,
   input  logic [32:0] jbr_bus_i,
   input  logic [32:0] exc_bus_i,
   output logic [31:0] inst_addr_o,
   input  logic [31:0] inst_rdata_i,
   output logic        IF_over_o,
   output logic [63:0] IF_ID_bus_o,
   output logic [31:0] IF_pc_o,
   output logic [31:0] IF_inst_o
);

   // The wait counter must be able to hold MEM_LATENCY itself, because the
   // ROM data is sampled on the edge where the count equals the latency.
   localparam int CNT_W = (MEM_LATENCY < 2) ? 1 : $clog2(MEM_LATENCY + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY);

   typedef enum logic {
      REQ  = 1'b0,
      DONE = 1'b1
   } fetchState_e;

   fetchState_e      state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      instR_q, instR_d;

   logic        jbrTaken;
   logic [31:0] jbrTarget;
   logic        excValid;
   logic [31:0] excPc;
   logic [31:0] nextPc;
   logic        ifOver;
   logic        advance;

   assign jbrTaken  = jbr_bus_i[32];
   assign jbrTarget = jbr_bus_i[31:0];
   assign excValid  = exc_bus_i[32];
   assign excPc     = exc_bus_i[31:0];

   // Redirect priority: an exception/ERET overrides a simultaneous branch,
   // and the branch target is simply dropped. Sequential pc wraps at 2^32.
   always_comb begin
      nextPc = pc_q + 32'd4;
      if (excValid) begin
         nextPc = excPc;
      end else if (jbrTaken) begin
         nextPc = jbrTarget;
      end
   end

   // A fetch is only reported complete while the slot is valid; an advance
   // request is only honoured when the current instruction is complete, so a
   // stray next_fetch during an outstanding fetch cannot skip it.
   assign ifOver  = IF_valid_i & (state_q == DONE);
   assign advance = next_fetch_i & ifOver;

   // Next-state logic. An exception redirect wins over everything except
   // reset and restarts the fetch from scratch; otherwise a pipeline advance
   // loads the next pc and restarts the fetch; otherwise the REQ state
   // counts valid cycles until the ROM data is due. In DONE the latched
   // instruction is simply held for as long as the pipeline stalls.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      instR_d = instR_q;

      if (excValid) begin
         pc_d    = nextPc;
         state_d = REQ;
         cnt_d   = '0;
      end else if (advance) begin
         pc_d    = nextPc;
         state_d = REQ;
         cnt_d   = '0;
      end else begin
         case (state_q)
            REQ: begin
               if (IF_valid_i) begin
                  if (cnt_q == CNT_LAST) begin
                     instR_d = inst_rdata_i;
                     cnt_d   = '0;
                     state_d = DONE;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end
            DONE: begin
               state_d = DONE;
            end
            default: begin
               state_d = REQ;
            end
         endcase
      end
   end

   // State register with synchronous reset; reset overrides any redirect or
   // fetch in progress at the same edge.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= REQ;
         pc_q    <= RESET_PC;
         cnt_q   <= '0;
         instR_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
         instR_q <= instR_d;
      end
   end

   assign inst_addr_o = pc_q;
   assign IF_over_o   = ifOver;
   assign IF_ID_bus_o = {pc_q, instR_q};
   assign IF_pc_o     = pc_q;
   assign IF_inst_o   = instR_q;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed bench for fetch_stage. Two instances share all control inputs:
// dut1 uses the default one-cycle ROM, dut2 a three-cycle ROM. Each has its
// own ROM model built from a delay line over a shared memory array.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

   logic        clk;
   logic        reset;
   logic        ifValid;
   logic        nextFetch;
   logic [32:0] jbrBus;
   logic [32:0] excBus;

   logic [31:0] instAddr1, romData1, ifPc1, ifInst1;
   logic        ifOver1;
   logic [63:0] idBus1;

   logic [31:0] instAddr2, romData2, ifPc2, ifInst2;
   logic        ifOver2;
   logic [63:0] idBus2;
   logic [31:0] rom2a, rom2b;

   logic [31:0] romMem [0:255];

   int compCount = 0;
   int failCount = 0;

   fetch_stage #(.RESET_PC(32'h0000_0000), .MEM_LATENCY(1)) dut1 (
      .clk_i        (clk),
      .reset_i      (reset),
      .IF_valid_i   (ifValid),
      .next_fetch_i (nextFetch),
      .jbr_bus_i    (jbrBus),
      .exc_bus_i    (excBus),
      .inst_addr_o  (instAddr1),
      .inst_rdata_i (romData1),
      .IF_over_o    (ifOver1),
      .IF_ID_bus_o  (idBus1),
      .IF_pc_o      (ifPc1),
      .IF_inst_o    (ifInst1)
   );

   fetch_stage #(.RESET_PC(32'h0000_0000), .MEM_LATENCY(3)) dut2 (
      .clk_i        (clk),
      .reset_i      (reset),
      .IF_valid_i   (ifValid),
      .next_fetch_i (nextFetch),
      .jbr_bus_i    (jbrBus),
      .exc_bus_i    (excBus),
      .inst_addr_o  (instAddr2),
      .inst_rdata_i (romData2),
      .IF_over_o    (ifOver2),
      .IF_ID_bus_o  (idBus2),
      .IF_pc_o      (ifPc2),
      .IF_inst_o    (ifInst2)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous ROMs: one register stage for dut1, three for dut2.
   always @(posedge clk) begin
      romData1 <= romMem[instAddr1[9:2]];
      rom2a    <= romMem[instAddr2[9:2]];
      rom2b    <= rom2a;
      romData2 <= rom2b;
   end

   // Advance n clock edges and settle 1 unit past the last one.
   task automatic applyStimulus(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One comparison: count it, and count and report it if it does not match.
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         romMem[i] = 32'h1000_0000 + 32'(i);
      end
      romMem[0] = 32'h2401_0005;

      reset     = 1'b1;
      ifValid   = 1'b1;
      nextFetch = 1'b0;
      jbrBus    = '0;
      excBus    = '0;

      // Reset for three cycles, then a first fetch from address 0.
      applyStimulus(3);
      checkOutput("rst_over",  64'(ifOver1), 64'd0);
      checkOutput("rst_bus",   idBus1, {32'h0, 32'h0});
      checkOutput("rst_addr",  64'(instAddr1), 64'h0);
      reset = 1'b0;
      applyStimulus(1);
      checkOutput("t1_over_c1", 64'(ifOver1), 64'd0);
      applyStimulus(1);
      checkOutput("t1_over_c2", 64'(ifOver1), 64'd1);
      checkOutput("t1_bus",     idBus1, {32'h0, 32'h2401_0005});

      // Sequential fetches 4, 8, C with next_fetch pulsed on each IF_over.
      for (int a = 4; a <= 12; a += 4) begin
         nextFetch = 1'b1;
         applyStimulus(1);
         nextFetch = 1'b0;
         checkOutput("t2_addr",   64'(instAddr1), 64'(a));
         checkOutput("t2_over_0", 64'(ifOver1), 64'd0);
         applyStimulus(1);
         checkOutput("t2_over_1", 64'(ifOver1), 64'd0);
         applyStimulus(1);
         checkOutput("t2_over_2", 64'(ifOver1), 64'd1);
         checkOutput("t2_inst",   64'(ifInst1), 64'(32'h1000_0000 + 32'(a / 4)));
      end
      checkOutput("t2_pc", 64'(ifPc1), 64'hC);

      // Stall in DONE for five cycles while the ROM contents change.
      romMem[3] = 32'hDEAD_BEEF;
      for (int c = 0; c < 5; c++) begin
         applyStimulus(1);
         checkOutput("t3_over", 64'(ifOver1), 64'd1);
         checkOutput("t3_inst", 64'(ifInst1), 64'h1000_0003);
      end

      // IF_over follows IF_valid while in DONE.
      ifValid = 1'b0;
      #1;
      checkOutput("t3_novalid", 64'(ifOver1), 64'd0);
      ifValid = 1'b1;
      #1;

      // Exception redirect from DONE back to address 8.
      excBus = {1'b1, 32'h8};
      applyStimulus(1);
      excBus = '0;
      checkOutput("exc8_addr",   64'(instAddr1), 64'h8);
      checkOutput("exc8_over_0", 64'(ifOver1), 64'd0);
      applyStimulus(1);
      checkOutput("exc8_over_1", 64'(ifOver1), 64'd0);
      applyStimulus(1);
      checkOutput("exc8_over_2", 64'(ifOver1), 64'd1);
      checkOutput("exc8_inst",   64'(ifInst1), 64'h1000_0002);

      // Taken branch from pc=8 to 0x40 on an advance.
      jbrBus    = {1'b1, 32'h40};
      nextFetch = 1'b1;
      applyStimulus(1);
      jbrBus    = '0;
      nextFetch = 1'b0;
      checkOutput("t4_addr",   64'(instAddr1), 64'h40);
      checkOutput("t4_over_0", 64'(ifOver1), 64'd0);
      applyStimulus(1);
      checkOutput("t4_over_1", 64'(ifOver1), 64'd0);
      applyStimulus(1);
      checkOutput("t4_over_2", 64'(ifOver1), 64'd1);
      checkOutput("t4_bus",    idBus1, {32'h40, 32'h1000_0010});

      // Advance to 0x44, then next_fetch during REQ (ignored) while IF_valid
      // is low (counter held), then resume.
      nextFetch = 1'b1;
      applyStimulus(1);
      checkOutput("hold_addr0", 64'(instAddr1), 64'h44);
      checkOutput("hold_over0", 64'(ifOver1), 64'd0);
      ifValid = 1'b0;
      applyStimulus(2);
      checkOutput("hold_addr1", 64'(instAddr1), 64'h44);
      checkOutput("hold_over1", 64'(ifOver1), 64'd0);
      nextFetch = 1'b0;
      ifValid   = 1'b1;
      applyStimulus(1);
      checkOutput("hold_over2", 64'(ifOver1), 64'd0);
      applyStimulus(1);
      checkOutput("hold_over3", 64'(ifOver1), 64'd1);
      checkOutput("hold_inst",  64'(ifInst1), 64'h1000_0011);

      // Mid-REQ exception together with a branch: exception wins and the
      // fetch counter restarts.
      nextFetch = 1'b1;
      applyStimulus(1);
      nextFetch = 1'b0;
      checkOutput("t5_pre_addr", 64'(instAddr1), 64'h48);
      applyStimulus(1);
      excBus = {1'b1, 32'h380};
      jbrBus = {1'b1, 32'h40};
      applyStimulus(1);
      excBus = '0;
      jbrBus = '0;
      checkOutput("t5_addr",   64'(instAddr1), 64'h380);
      checkOutput("t5_over_0", 64'(ifOver1), 64'd0);
      applyStimulus(1);
      checkOutput("t5_over_1", 64'(ifOver1), 64'd0);
      applyStimulus(1);
      checkOutput("t5_over_2", 64'(ifOver1), 64'd1);
      checkOutput("t5_bus",    idBus1, {32'h380, 32'h1000_00E0});

      // Reset during a three-cycle-latency fetch, then refetch from 0.
      excBus = {1'b1, 32'h100};
      applyStimulus(1);
      excBus = '0;
      applyStimulus(1);
      checkOutput("t6_pre_addr", 64'(instAddr2), 64'h100);
      checkOutput("t6_pre_over", 64'(ifOver2), 64'd0);
      reset = 1'b1;
      applyStimulus(1);
      checkOutput("t6_rst_addr", 64'(instAddr2), 64'h0);
      checkOutput("t6_rst_over", 64'(ifOver2), 64'd0);
      checkOutput("t6_rst_bus",  idBus2, {32'h0, 32'h0});
      reset = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         applyStimulus(1);
         checkOutput("t6_wait_over", 64'(ifOver2), 64'd0);
      end
      applyStimulus(1);
      checkOutput("t6_over",  64'(ifOver2), 64'd1);
      checkOutput("t6_inst",  64'(ifInst2), 64'h2401_0005);
      checkOutput("t6_pc",    64'(ifPc2), 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
      $finish;
   end

endmodule
